// File: rtl/ext_cpu_hart_ctrl.sv
// Boot and run controller for NHARTS cve2 harts: OBI-programmed boot addresses,
// staggered in-order hart release, per-hart halt and debug-request pulses.
module ext_cpu_hart_ctrl #(
  parameter int unsigned NHARTS        = 2,
  parameter logic [31:0] BOOT_ADDR_RST = 32'h2001_0000,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned DBG_PULSE     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [31:0]            addr_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            wdata_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [NHARTS-1:0]      hart_rst_o,
  output logic [NHARTS-1:0]      fetch_enable_o,
  output logic [32*NHARTS-1:0]   boot_addr_o,
  output logic [NHARTS-1:0]      debug_req_o,
  output logic                   busy_o
);

  localparam int unsigned DW = $clog2(DBG_PULSE + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [15:0]       r_cnt, w_cnt_nxt;
  logic [NHARTS-1:0] r_pend, r_mask, r_hart_rst, r_fetch_en;
  logic [NHARTS-1:0] w_fetch_en_nxt, w_low, w_dbg_set, w_halt_vec;
  logic [15:0]       r_stagger;
  logic              r_rvalid;
  logic [31:0]       r_rdata, w_rdata;
  logic              w_wr, w_rd;
  logic [5:0]        w_idx;
  logic [31:0]       w_bmask, w_wmasked;
  logic              w_start, w_halt_all, w_hold_entry, w_release, w_busy;
  logic              w_unused_addr;

  assign w_unused_addr = ^{addr_i[31:8], addr_i[1:0]};

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;

  assign w_idx     = addr_i[7:2];
  assign w_wr      = req_i & we_i;
  assign w_rd      = req_i & ~we_i;
  assign w_bmask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_wmasked = wdata_i & w_bmask;

  assign w_start    = w_wr && (w_idx == 6'h00) && w_wmasked[0];
  assign w_halt_all = w_wr && (w_idx == 6'h00) && w_wmasked[1];
  assign w_dbg_set  = (w_wr && (w_idx == 6'h04)) ? w_wmasked[NHARTS-1:0] : '0;
  assign w_halt_vec = (w_wr && (w_idx == 6'h05)) ? w_wmasked[NHARTS-1:0] : '0;

  assign w_busy         = (r_state != S_IDLE);
  assign busy_o         = w_busy;
  assign hart_rst_o     = r_hart_rst;
  assign fetch_enable_o = r_fetch_en;

  // Lowest pending hart as a one-hot vector (two's-complement isolate trick).
  assign w_low        = r_pend & (~r_pend + NHARTS'(1));
  assign w_hold_entry = (r_state == S_IDLE) && w_start && (|r_mask) && !w_halt_all;
  assign w_release    = (r_state == S_REL) && !w_halt_all;

  // HALT is applied after the release so it wins for a hart released this cycle.
  always_comb begin
    w_fetch_en_nxt = r_fetch_en;
    if (w_hold_entry) w_fetch_en_nxt = w_fetch_en_nxt & ~r_mask;
    if (w_release)    w_fetch_en_nxt = w_fetch_en_nxt | w_low;
    w_fetch_en_nxt = w_fetch_en_nxt & ~w_halt_vec;
    if (w_halt_all)   w_fetch_en_nxt = '0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hold_entry) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 16'(RST_CYCLES - 1);
        end
      end
      S_HOLD, S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_REL;
        else             w_cnt_nxt   = r_cnt - 16'd1;
      end
      S_REL: begin
        if ((r_pend & ~w_low) == '0) begin
          w_state_nxt = S_IDLE;
        end else if (r_stagger != '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = r_stagger - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_halt_all) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_stagger  <= '0;
      r_hart_rst <= '1;
      r_fetch_en <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fetch_en <= w_fetch_en_nxt;

      if (w_halt_all)        r_pend <= '0;
      else if (w_hold_entry) r_pend <= r_mask;
      else if (w_release)    r_pend <= r_pend & ~w_low;

      if (w_hold_entry)   r_hart_rst <= r_hart_rst | r_mask;
      else if (w_release) r_hart_rst <= r_hart_rst & ~w_low;

      if (w_wr && (w_idx == 6'h02))
        r_mask <= (r_mask & ~w_bmask[NHARTS-1:0]) | w_wmasked[NHARTS-1:0];
      if (w_wr && (w_idx == 6'h03))
        r_stagger <= (r_stagger & ~w_bmask[15:0]) | w_wmasked[15:0];

      r_rvalid <= req_i;
      r_rdata  <= w_rd ? w_rdata : '0;
    end
  end

  for (genvar h = 0; h < NHARTS; h++) begin : g_hart
    logic [31:8]   r_boot;
    logic [DW-1:0] r_dbg;

    // A running hart's boot address is frozen: writes only land while it is held in reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_boot <= BOOT_ADDR_RST[31:8];
      end else if (w_wr && (w_idx == 6'(16 + h)) && r_hart_rst[h]) begin
        r_boot <= (r_boot & ~w_bmask[31:8]) | w_wmasked[31:8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i)              r_dbg <= '0;
      else if (w_dbg_set[h])  r_dbg <= DW'(DBG_PULSE);
      else if (r_dbg != '0)   r_dbg <= r_dbg - DW'(1);
    end

    assign debug_req_o[h]         = (r_dbg != '0);
    assign boot_addr_o[32*h +: 32] = {r_boot, 8'h00};
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      6'h01: begin
        w_rdata[NHARTS-1:0] = r_fetch_en;
        w_rdata[31]         = w_busy;
      end
      6'h02: w_rdata[NHARTS-1:0] = r_mask;
      6'h03: w_rdata[15:0]       = r_stagger;
      default: begin
        for (int unsigned h = 0; h < NHARTS; h++) begin
          if (w_idx == 6'(16 + h)) w_rdata = boot_addr_o[32*h +: 32];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ext_cpu_hart_ctrl.sv
// Directed bench for ext_cpu_hart_ctrl: register-access vector table plus
// hand-timed sequences for release stagger, halts, debug pulses and reset abort.
module tb_ext_cpu_hart_ctrl;

  localparam int unsigned NH = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_i = 1'b0;
  logic [31:0]       addr_i = '0;
  logic              we_i = 1'b0;
  logic [3:0]        be_i = '0;
  logic [31:0]       wdata_i = '0;
  logic              gnt_o, rvalid_o, busy_o;
  logic [31:0]       rdata_o;
  logic [NH-1:0]     hart_rst_o, fetch_enable_o, debug_req_o;
  logic [32*NH-1:0]  boot_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ext_cpu_hart_ctrl #(
    .NHARTS(NH),
    .BOOT_ADDR_RST(32'h2001_0000),
    .RST_CYCLES(8),
    .DBG_PULSE(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .hart_rst_o(hart_rst_o), .fetch_enable_o(fetch_enable_o),
    .boot_addr_o(boot_addr_o), .debug_req_o(debug_req_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    #1;
    chk("gnt", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0; we_i = 1'b0;
    chk("rvalid", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] rd;
    access(1'b1, addr, be, wd, rd);
    chk("wr_rdata", rd, 32'd0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    access(1'b0, addr, 4'hF, 32'd0, rd);
    chk(name, rd, exp);
  endtask

  task automatic outs(input string name, input logic [NH-1:0] rst, input logic [NH-1:0] fe,
                      input logic busy);
    chk({name, "_rst"},  32'(hart_rst_o),     32'(rst));
    chk({name, "_fe"},   32'(fetch_enable_o), 32'(fe));
    chk({name, "_busy"}, 32'(busy_o),         32'(busy));
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;

    add(0, 32'h40, 4'hF, 32'h0,          32'h2001_0000);
    add(0, 32'h44, 4'hF, 32'h0,          32'h2001_0000);
    add(0, 32'h04, 4'hF, 32'h0,          32'h0);
    add(0, 32'h08, 4'hF, 32'h0,          32'h0);
    add(0, 32'h0C, 4'hF, 32'h0,          32'h0);
    add(0, 32'h00, 4'hF, 32'h0,          32'h0);
    add(0, 32'h10, 4'hF, 32'h0,          32'h0);
    add(0, 32'h14, 4'hF, 32'h0,          32'h0);
    add(0, 32'h48, 4'hF, 32'h0,          32'h0);
    add(1, 32'h44, 4'hF, 32'hF001_00FF,  32'h0);
    add(0, 32'h44, 4'hF, 32'h0,          32'hF001_0000);
    add(1, 32'h44, 4'h8, 32'h12FF_FFFF,  32'h0);
    add(0, 32'h44, 4'hF, 32'h0,          32'h1201_0000);
    add(1, 32'h44, 4'h8, 32'hF000_0000,  32'h0);
    add(0, 32'h44, 4'hF, 32'h0,          32'hF001_0000);
    add(1, 32'h08, 4'h1, 32'hFFFF_FFFF,  32'h0);
    add(0, 32'h08, 4'hF, 32'h0,          32'h3);
    add(1, 32'h0C, 4'h3, 32'hABCD_0005,  32'h0);
    add(0, 32'h0C, 4'hF, 32'h0,          32'h5);
    add(1, 32'h20, 4'hF, 32'hFFFF_FFFF,  32'h0);
    add(0, 32'h20, 4'hF, 32'h0,          32'h0);
    add(1, 32'h00, 4'h2, 32'h0000_0101,  32'h0);
    add(0, 32'h04, 4'hF, 32'h0,          32'h0);

    // Test 1: reset state
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    outs("rst", 2'b11, 2'b00, 1'b0);
    chk("rst_dbg",    32'(debug_req_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o),    32'd0);
    chk("rst_rdata",  rdata_o,          32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    tick();
    chk("rvalid_drop", 32'(rvalid_o), 32'd0);
    chk("start_be_gated_busy", 32'(busy_o), 32'd0);

    // Test 2: MASK=3 STAGGER=5, staggered release
    wr(32'h00, 4'hF, 32'h1);
    outs("t2_k0", 2'b11, 2'b00, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      outs($sformatf("t2_k%0d", k),
           (k < 9) ? 2'b11 : (k < 15) ? 2'b10 : 2'b00,
           (k < 9) ? 2'b00 : (k < 15) ? 2'b01 : 2'b11,
           k < 15);
    end
    chk("t2_boot0", boot_addr_o[31:0],  32'h2001_0000);
    chk("t2_boot1", boot_addr_o[63:32], 32'hF001_0000);

    // Test 3: frozen boot address of running hart, per-hart HALT
    wr(32'h40, 4'hF, 32'h1234_5600);
    rd_chk("t3_boot0_frozen", 32'h40, 32'h2001_0000);
    wr(32'h14, 4'hF, 32'h1);
    outs("t3_halt", 2'b00, 2'b10, 1'b0);
    rd_chk("t3_status", 32'h04, 32'h2);

    // Test 4: debug pulse length and restart
    wr(32'h10, 4'hF, 32'h2);
    chk("t4_dbg_k0", 32'(debug_req_o), 32'd2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t4_dbg_k%0d", k), 32'(debug_req_o), (k < 4) ? 32'd2 : 32'd0);
    end
    wr(32'h10, 4'hF, 32'h2);
    tick();
    chk("t4r_dbg_k1", 32'(debug_req_o), 32'd2);
    wr(32'h10, 4'hF, 32'h2);
    chk("t4r_dbg_k2", 32'(debug_req_o), 32'd2);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk($sformatf("t4r_dbg_k%0d", k), 32'(debug_req_o), (k < 6) ? 32'd2 : 32'd0);
    end

    // Test 5: STAGGER=0 back-to-back release; START while busy ignored
    wr(32'h0C, 4'hF, 32'h0);
    wr(32'h00, 4'hF, 32'h1);
    outs("t5_k0", 2'b11, 2'b00, 1'b1);
    tick(); tick();
    wr(32'h00, 4'hF, 32'h1);
    for (int k = 4; k <= 10; k++) begin
      tick();
      outs($sformatf("t5_k%0d", k),
           (k < 9) ? 2'b11 : (k == 9) ? 2'b10 : 2'b00,
           (k < 9) ? 2'b00 : (k == 9) ? 2'b01 : 2'b11,
           k < 10);
    end

    // HALT of hart 0 in its RELEASE cycle: reset still drops, fetch stays off
    wr(32'h08, 4'hF, 32'h1);
    wr(32'h00, 4'hF, 32'h1);
    outs("hr_k0", 2'b01, 2'b10, 1'b1);
    for (int k = 1; k <= 8; k++) tick();
    outs("hr_k8", 2'b01, 2'b10, 1'b1);
    wr(32'h14, 4'hF, 32'h1);
    outs("hr_k9", 2'b00, 2'b10, 1'b0);

    // HALT_ALL in GAP
    wr(32'h08, 4'hF, 32'h3);
    wr(32'h0C, 4'hF, 32'h5);
    wr(32'h00, 4'hF, 32'h1);
    for (int k = 1; k <= 9; k++) tick();
    outs("ha_k9", 2'b10, 2'b01, 1'b1);
    tick();
    wr(32'h00, 4'hF, 32'h2);
    outs("ha_k11", 2'b10, 2'b00, 1'b0);
    for (int k = 12; k <= 17; k++) tick();
    outs("ha_k17", 2'b10, 2'b00, 1'b0);

    // Test 6: reset mid-GAP
    wr(32'h00, 4'hF, 32'h1);
    for (int k = 1; k <= 9; k++) tick();
    outs("t6_k9", 2'b10, 2'b01, 1'b1);
    wr(32'h10, 4'hF, 32'h1);
    chk("t6_dbg", 32'(debug_req_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    outs("t6_rst", 2'b11, 2'b00, 1'b0);
    chk("t6_rst_dbg",    32'(debug_req_o),  32'd0);
    chk("t6_rst_rvalid", 32'(rvalid_o),     32'd0);
    chk("t6_rst_boot0",  boot_addr_o[31:0],  32'h2001_0000);
    chk("t6_rst_boot1",  boot_addr_o[63:32], 32'h2001_0000);
    rd_chk("t6_mask",    32'h08, 32'h0);
    rd_chk("t6_stagger", 32'h0C, 32'h0);
    rd_chk("t6_boot1",   32'h44, 32'h2001_0000);
    wr(32'h00, 4'hF, 32'h1);
    chk("t6_mask0_busy", 32'(busy_o), 32'd0);
    tick();
    outs("t6_mask0", 2'b11, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
